// File: rtl/if_id_queue.sv
// IF->ID instruction queue: DEPTH-entry circular buffer of {pc, pc_incr, inst}
// with valid/ready on both sides and a flush that drops every buffered entry.
module if_id_queue #(
  parameter int WORD      = 64,
  parameter int INST_SIZE = 32,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD-1:0]          in_pc,
  input  logic [WORD-1:0]          in_pc_incr,
  input  logic [INST_SIZE-1:0]     in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD-1:0]          out_pc,
  output logic [WORD-1:0]          out_pc_incr,
  output logic [INST_SIZE-1:0]     out_inst,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [WORD-1:0]      pc;
    logic [WORD-1:0]      pc_incr;
    logic [INST_SIZE-1:0] inst;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;

  logic   w_push;
  logic   w_pop;
  entry_t w_head;

  // Ready depends only on registered occupancy, so a full queue never passes through.
  assign in_ready  = (r_count != L_FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign count     = r_count;

  assign w_head      = r_mem[r_rp];
  assign out_pc      = out_valid ? w_head.pc      : '0;
  assign out_pc_incr = out_valid ? w_head.pc_incr : '0;
  assign out_inst    = out_valid ? w_head.inst    : '0;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the entry array is reset too, so no stale bundle from before reset
  // can ever be observed; flush deliberately leaves contents untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !flush) begin
      r_mem[r_wp] <= '{pc: in_pc, pc_incr: in_pc_incr, inst: in_inst};
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4).
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [63:0] in_pc_incr;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [63:0] out_pc_incr;
  logic [31:0] out_inst;
  logic        flush;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;

  if_id_queue #(.WORD(64), .INST_SIZE(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_incr(in_pc_incr), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_incr(out_pc_incr), .out_inst(out_inst),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc);
    in_valid   = v;
    in_pc      = pc;
    in_pc_incr = pc + 64'd4;
    in_inst    = inst_of(pc);
  endtask

  task automatic push1(input logic [63:0] pc);
    drive(1'b1, pc);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int next;
    int got;
    int m_count;
    logic do_push;
    logic do_pop;

    rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_pc_incr = '0; in_inst = '0;
    out_ready = 1'b0; flush = 1'b0;
    #3;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_pc",    out_pc, 64'd0);
    #14 rst_n = 1'b1;

    // Mid-stream asynchronous reset with three entries buffered.
    push1(64'h0); push1(64'h4); push1(64'h8);
    chk("pre_rst_count", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    chk("arst_inst",  64'(out_inst), 64'd0);
    #2 rst_n = 1'b1;
    in_valid = 1'b1; in_pc = 64'h0; in_pc_incr = 64'h4; in_inst = 32'h8B020020;
    tick();
    in_valid = 1'b0;
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_pc",    out_pc, 64'h0);
    chk("first_incr",  out_pc_incr, 64'h4);
    chk("first_inst",  64'(out_inst), 64'h8B020020);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Fill to full, then a fifth push is held off.
    for (int i = 0; i < 4; i++) begin
      push1(64'(4 * i));
      chk("fill_count", 64'(count), 64'(i + 1));
      chk("fill_head",  out_pc, 64'h0);
    end
    chk("full_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 64'h10);
    tick();
    chk("full_hold_count", 64'(count), 64'd4);
    chk("full_hold_pc",    out_pc, 64'h0);
    in_valid = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush1_count", 64'(count), 64'd0);
    chk("flush1_ready", 64'(in_ready), 64'd1);

    // Ten-bundle stream with toggling out_ready; pointers wrap twice.
    next = 0; got = 0; m_count = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      drive(next < 10, 64'(4 * next));
      out_ready = (c % 2 == 0);
      chk("ord_ready", 64'(in_ready), 64'(m_count != 4));
      chk("ord_count", 64'(count), 64'(m_count));
      do_push = in_valid && (m_count != 4);
      do_pop  = out_ready && (m_count != 0);
      if (do_pop) chk("ord_pc", out_pc, 64'(4 * got));
      tick();
      if (do_pop)  begin got++;  m_count--; end
      if (do_push) begin next++; m_count++; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("ord_total", 64'(got), 64'd10);
    chk("ord_empty", 64'(count), 64'd0);

    // Simultaneous push/pop at count=2 keeps occupancy constant.
    push1(64'h200); push1(64'h204);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'(32'h208 + 4 * i));
      out_ready = 1'b1;
      chk("sim_pc", out_pc, 64'(32'h200 + 4 * i));
      tick();
      chk("sim_count", 64'(count), 64'd2);
    end
    out_ready = 1'b0;
    push1(64'h214); push1(64'h218);
    chk("sim_full", 64'(count), 64'd4);
    drive(1'b1, 64'h21C); out_ready = 1'b1;
    chk("sim_full_ready", 64'(in_ready), 64'd0);
    chk("sim_full_pc",    out_pc, 64'h20C);
    tick();
    chk("sim_full_count", 64'(count), 64'd3);
    chk("sim_full_next",  out_pc, 64'h210);
    chk("sim_ready_rise", 64'(in_ready), 64'd1);

    // Flush beats a same-cycle push and pop.
    drive(1'b1, 64'h40); out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_pc",    out_pc, 64'h0);
    push1(64'h100);
    chk("post_flush_pc",    out_pc, 64'h100);
    chk("post_flush_count", 64'(count), 64'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("post_flush_empty", 64'(count), 64'd0);

    // Backpressure: head stays stable while IF keeps pushing.
    push1(64'h300);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'(32'h304 + 4 * i));
      tick();
      chk("bp_pc",   out_pc, 64'h300);
      chk("bp_incr", out_pc_incr, 64'h304);
      chk("bp_inst", 64'(out_inst), 64'(inst_of(64'h300)));
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(count), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
